// File: rtl/aibcr3_str_dll_lockctl.sv
// Strobe-DLL lock controller.
// Integrates phase-detector up/down votes over a fixed window, steps the
// 11-bit delay code by one when the vote clears a threshold, and declares
// lock after enough consecutive windows that did not advance the code.
module aibcr3_str_dll_lockctl #(
    parameter int SETTLE_CYC = 8,
    parameter int WIN_CYC    = 16,
    parameter int THRESH     = 4,
    parameter int LOCK_CNT   = 4
) (
    input  logic        clk_pll,
    input  logic        rst_n,
    input  logic        lock_req,
    input  logic        t_up,
    input  logic        t_down,
    input  logic [10:0] csr_init_code,
    output logic [7:0]  f_gray,
    output logic [2:0]  i_gray,
    output logic [10:0] code_bin,
    output logic        code_valid,
    output logic        phdet_reset_n,
    output logic        dll_lock,
    output logic        sat_err
);

    typedef enum logic [2:0] {IDLE, PDRST, SETTLE, MEASURE, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_HOLD, DIR_UP, DIR_DN} dir_t;

    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]        WIN_LAST    = 8'(WIN_CYC - 1);
    localparam logic signed [8:0] THR_POS     = 9'(THRESH);
    localparam logic signed [8:0] THR_NEG     = 9'(-THRESH);
    localparam logic [3:0]        LOCK_TGT    = 4'(LOCK_CNT);

    state_t            state;
    dir_t              last_dir;
    dir_t              dir;
    logic [7:0]        cyc_cnt;
    logic signed [8:0] acc;
    logic signed [8:0] vote;
    logic [3:0]        lock_ctr;
    logic [3:0]        lock_ctr_nxt;
    logic [10:0]       code;
    logic              sat_hit;
    logic              non_adv;

    assign code_bin = code;

    // Translate the phase-detector pair into a signed single-cycle vote
    always_comb begin
        vote = 9'sd0;
        if (t_up && !t_down) begin
            vote = 9'sd1;
        end else if (!t_up && t_down) begin
            vote = -9'sd1;
        end
    end

    // Step decision and lock bookkeeping for the window that just closed
    always_comb begin
        dir = DIR_HOLD;
        if (acc >= THR_POS) begin
            dir = DIR_UP;
        end else if (acc <= THR_NEG) begin
            dir = DIR_DN;
        end
        sat_hit = ((dir == DIR_UP) && (code == 11'h7FF)) ||
                  ((dir == DIR_DN) && (code == 11'h000));
        non_adv = (dir == DIR_HOLD) ||
                  ((dir == DIR_UP) && (last_dir == DIR_DN)) ||
                  ((dir == DIR_DN) && (last_dir == DIR_UP));
        lock_ctr_nxt = 4'd0;
        if (!sat_hit && non_adv) begin
            lock_ctr_nxt = (lock_ctr == 4'd15) ? 4'd15 : lock_ctr + 4'd1;
        end
    end

    // Main loop FSM: reset phase detector, settle, measure, update code
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_dir      <= DIR_HOLD;
            cyc_cnt       <= 8'd0;
            acc           <= 9'sd0;
            lock_ctr      <= 4'd0;
            code          <= 11'd0;
            code_valid    <= 1'b0;
            phdet_reset_n <= 1'b0;
            dll_lock      <= 1'b0;
            sat_err       <= 1'b0;
        end else if (state == IDLE) begin
            phdet_reset_n <= 1'b0;
            code_valid    <= 1'b0;
            dll_lock      <= 1'b0;
            cyc_cnt       <= 8'd0;
            if (lock_req) begin
                state    <= PDRST;
                code     <= csr_init_code;
                sat_err  <= 1'b0;
                lock_ctr <= 4'd0;
                last_dir <= DIR_HOLD;
            end
        end else if (!lock_req) begin
            state         <= IDLE;
            phdet_reset_n <= 1'b0;
            code_valid    <= 1'b0;
            dll_lock      <= 1'b0;
            cyc_cnt       <= 8'd0;
        end else begin
            unique case (state)
                PDRST: begin
                    if (cyc_cnt == 8'd1) begin
                        state         <= SETTLE;
                        cyc_cnt       <= 8'd0;
                        phdet_reset_n <= 1'b1;
                        code_valid    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (cyc_cnt == SETTLE_LAST) begin
                        state   <= MEASURE;
                        cyc_cnt <= 8'd0;
                        acc     <= 9'sd0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                MEASURE: begin
                    acc <= acc + vote;
                    if (cyc_cnt == WIN_LAST) begin
                        state   <= UPDATE;
                        cyc_cnt <= 8'd0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                UPDATE: begin
                    acc      <= 9'sd0;
                    lock_ctr <= lock_ctr_nxt;
                    if (lock_ctr_nxt >= LOCK_TGT) begin
                        dll_lock <= 1'b1;
                    end
                    if (dir != DIR_HOLD) begin
                        last_dir <= dir;
                    end
                    if (sat_hit) begin
                        sat_err <= 1'b1;
                        state   <= MEASURE;
                    end else if (dir == DIR_UP) begin
                        code  <= code + 11'd1;
                        state <= SETTLE;
                    end else if (dir == DIR_DN) begin
                        code  <= code - 11'd1;
                        state <= SETTLE;
                    end else begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gray-coded delay-line outputs trail the code register by one cycle
    always_ff @(posedge clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            f_gray <= 8'd0;
            i_gray <= 3'd0;
        end else begin
            f_gray <= code[10:3] ^ {1'b0, code[10:4]};
            i_gray <= code[2:0] ^ {1'b0, code[2:1]};
        end
    end

endmodule

// File: tb/tb_aibcr3_str_dll_lockctl.sv
// Testbench for the strobe-DLL lock controller.
// Stimulus drives randomized vote windows and pushes cycle-tagged expected
// outputs into a scoreboard; a monitor pops and compares them.
module tb_aibcr3_str_dll_lockctl;

    localparam int SETTLE_CYC = 8;
    localparam int WIN_CYC    = 16;
    localparam int THRESH     = 4;
    localparam int LOCK_CNT   = 4;

    logic        clk_pll = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock_req = 1'b0;
    logic        t_up = 1'b0;
    logic        t_down = 1'b0;
    logic [10:0] csr_init_code = 11'd0;
    logic [7:0]  f_gray;
    logic [2:0]  i_gray;
    logic [10:0] code_bin;
    logic        code_valid;
    logic        phdet_reset_n;
    logic        dll_lock;
    logic        sat_err;

    aibcr3_str_dll_lockctl #(
        .SETTLE_CYC(SETTLE_CYC),
        .WIN_CYC(WIN_CYC),
        .THRESH(THRESH),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk_pll(clk_pll),
        .rst_n(rst_n),
        .lock_req(lock_req),
        .t_up(t_up),
        .t_down(t_down),
        .csr_init_code(csr_init_code),
        .f_gray(f_gray),
        .i_gray(i_gray),
        .code_bin(code_bin),
        .code_valid(code_valid),
        .phdet_reset_n(phdet_reset_n),
        .dll_lock(dll_lock),
        .sat_err(sat_err)
    );

    always #5 clk_pll = ~clk_pll;

    typedef struct {
        int         tag;
        string      name;
        logic [10:0] code;
        logic [7:0] fg;
        logic [2:0] ig;
        logic       cv;
        logic       lk;
        logic       se;
        logic       pr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   plan[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: the loop as the specification describes it
    int   m_code = 0;
    int   m_cnt = 0;
    int   m_last = 0;
    bit   m_sat = 1'b0;
    bit   m_lock = 1'b0;

    always @(posedge clk_pll) cyc <= cyc + 1;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic push(input int tag, input string name, input int code, input int gsrc,
                        input bit cv, input bit lk, input bit se, input bit pr);
        exp_t e;
        e.tag  = tag;
        e.name = name;
        e.code = 11'(code);
        e.fg   = 8'(gray(gsrc >> 3));
        e.ig   = 3'(gray(gsrc & 7));
        e.cv   = cv;
        e.lk   = lk;
        e.se   = se;
        e.pr   = pr;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (code_bin !== e.code || f_gray !== e.fg || i_gray !== e.ig ||
            code_valid !== e.cv || dll_lock !== e.lk || sat_err !== e.se ||
            phdet_reset_n !== e.pr) begin
            miscompares++;
            $display("[TB] FAIL %s @cyc %0d: got code=%03h f=%02h i=%0h cv=%b lk=%b se=%b pr=%b, expected code=%03h f=%02h i=%0h cv=%b lk=%b se=%b pr=%b",
                     e.name, cyc, code_bin, f_gray, i_gray, code_valid, dll_lock, sat_err,
                     phdet_reset_n, e.code, e.fg, e.ig, e.cv, e.lk, e.se, e.pr);
        end
    endtask

    // Monitor: compare every expectation due this cycle, flag any that were skipped
    always @(negedge clk_pll) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.tag < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s: expectation for cycle %0d missed at %0d", mon_e.name, mon_e.tag, cyc);
            end else begin
                checkOutput(mon_e);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_pll);
    endtask

    task automatic applyReset();
        int t;
        t = cyc;
        rst_n = 1'b0;
        lock_req = 1'b0;
        t_up = 1'b0;
        t_down = 1'b0;
        m_code = 0;
        m_sat = 1'b0;
        m_lock = 1'b0;
        push(t + 1, "reset", 0, 0, 0, 0, 0, 0);
        wait_cyc(t + 2);
        rst_n = 1'b1;
        wait_cyc(t + 3);
    endtask

    // Raise lock_req with a new init code; expect two PD-reset cycles then settle
    task automatic startLock(input int init, output int c0);
        int oldc;
        c0 = cyc;
        lock_req = 1'b1;
        csr_init_code = 11'(init);
        t_up = 1'b0;
        t_down = 1'b0;
        oldc = m_code;
        m_code = init;
        m_sat = 1'b0;
        m_cnt = 0;
        m_last = 0;
        m_lock = 1'b0;
        push(c0 + 1, "pdrst0", m_code, oldc, 0, 0, 0, 0);
        push(c0 + 2, "pdrst1", m_code, m_code, 0, 0, 0, 0);
        push(c0 + 3, "settle_entry", m_code, m_code, 1, 0, 0, 1);
    endtask

    // Run the windows in plan[]; drop lock_req in window drop_win if >= 0
    task automatic applyStimulus(input int init, input int drop_win);
        int c0, m, u, acc, dir, oldc, drop_k;
        bit changed, uv, dv;
        startLock(init, c0);
        m = c0 + 3 + SETTLE_CYC;
        u = m;
        drop_k = $urandom_range(2, WIN_CYC - 1);
        for (int w = 0; w < plan.size(); w++) begin
            acc = 0;
            for (int k = 1; k <= WIN_CYC; k++) begin
                wait_cyc(m + k - 1);
                if (w == drop_win && k == drop_k) begin
                    lock_req = 1'b0;
                    push(m + k, "drop", m_code, m_code, 0, 0, m_sat, 0);
                    wait_cyc(m + k + 1);
                    return;
                end
                case (plan[w])
                    1:       begin uv = ($urandom % 4) != 0; dv = ($urandom % 4) == 0; end
                    -1:      begin uv = ($urandom % 4) == 0; dv = ($urandom % 4) != 0; end
                    2:       begin uv = 1'b1; dv = 1'b1; end
                    default: begin uv = 1'($urandom % 2); dv = 1'($urandom % 2); end
                endcase
                t_up = uv;
                t_down = dv;
                if (uv && !dv) acc++;
                else if (dv && !uv) acc--;
            end
            u = m + WIN_CYC + 1;
            dir = (acc >= THRESH) ? 1 : (acc <= -THRESH) ? -1 : 0;
            oldc = m_code;
            changed = 1'b0;
            if ((dir == 1 && m_code == 2047) || (dir == -1 && m_code == 0)) begin
                m_sat = 1'b1;
                m_cnt = 0;
            end else begin
                m_code = m_code + dir;
                changed = (dir != 0);
                if (dir == 0 || (m_last != 0 && dir == -m_last))
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                else
                    m_cnt = 0;
            end
            if (dir != 0) m_last = dir;
            if (m_cnt >= LOCK_CNT) m_lock = 1'b1;
            push(u, "update", m_code, oldc, 1, m_lock, m_sat, 1);
            push(u + 1, "gray", m_code, m_code, 1, m_lock, m_sat, 1);
            m = changed ? u + SETTLE_CYC : u;
        end
        wait_cyc(u + 1);
        lock_req = 1'b0;
        push(u + 2, "idle", m_code, m_code, 0, 0, m_sat, 0);
        wait_cyc(u + 3);
    endtask

    // Asynchronous reset while settling: outputs must clear before any clock edge
    task automatic resetMidSettle(input int init);
        int c0;
        exp_t z;
        startLock(init, c0);
        wait_cyc(c0 + 5);
        #2;
        rst_n = 1'b0;
        #1;
        z.tag = cyc; z.name = "async_reset"; z.code = 11'd0; z.fg = 8'd0; z.ig = 3'd0;
        z.cv = 1'b0; z.lk = 1'b0; z.se = 1'b0; z.pr = 1'b0;
        checkOutput(z);
        lock_req = 1'b0;
        m_code = 0;
        m_sat = 1'b0;
        m_lock = 1'b0;
        @(negedge clk_pll);
        rst_n = 1'b1;
        @(negedge clk_pll);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish (%0d vectors so far)", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk_pll);
        applyReset();
        plan = '{1, 1, 1, -1, 1, -1, 1, -1, 1};
        applyStimulus(11'h200, -1);
        plan = '{2, 2, 2, 2, 2};
        applyStimulus(11'h155, -1);
        plan = '{1, 1, 1, 1};
        applyStimulus(11'h7FF, -1);
        plan = '{-1, -1, -1, -1};
        applyStimulus(11'h000, -1);
        plan = '{1};
        applyStimulus(11'h007, -1);
        plan = '{2, 2, 2, 2, 2, 2};
        applyStimulus(11'h155, 5);
        plan = '{1, -1};
        applyStimulus(11'h3A0, -1);
        for (int r = 0; r < 3; r++) begin
            plan.delete();
            for (int i = 0; i < 6; i++) plan.push_back(int'($urandom_range(0, 3)) - 1);
            applyStimulus(int'($urandom_range(0, 2047)), -1);
        end
        resetMidSettle(11'h2C4);
        plan = '{-1, 2};
        applyStimulus(11'h008, -1);
        wait_cyc(cyc + 3);
        if (sb.size() != 0) begin
            miscompares += sb.size();
            vectors += sb.size();
            $display("[TB] FAIL scoreboard: %0d expectations never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
